ecg_interval_calc: RTL



---
 rtl/ecg_interval_pkg.sv | 25 ++
 rtl/ecg_seq_divider.sv | 60 ++++++
 rtl/ecg_interval_calc.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ecg_interval_pkg.sv
// Shared definitions for the ECG interval calculator: FSM encoding,
// default widths and the heart-rate dividend helper.
// Optional build macro: ECG_INTERVAL_RR_AVG_EN (4-beat averaged RR).
package ecg_interval_pkg;

   localparam int POS_W_DEF  = 12;
   localparam int HR_W_DEF   = 8;
   localparam int FS_DEF     = 250;
   localparam int DIV_W_DEF  = 16;
   localparam int RR_MIN_DEF = 50;

   // Beats per minute = 60 * FS / RR, so the dividend is fixed per build
   function automatic int hr_dividend(input int fs);
      return 60 * fs;
   endfunction

   localparam int HR_DIVIDEND = 60 * FS_DEF;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CAPTURE = 3'd1;
   localparam logic [2:0] ST_CHECK   = 3'd2;
   localparam logic [2:0] ST_DIVIDE  = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/ecg_seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, fixed DIV_W
// cycle latency from start to a one-cycle done pulse.
module ecg_seq_divider #(
   parameter int DIV_W = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DIV_W-1:0] dividend,
   input  logic [DIV_W-1:0] divisor,
   output logic [DIV_W-1:0] quotient,
   output logic             done
);

   localparam int CNT_W = $clog2(DIV_W + 1);

   logic [DIV_W:0]   rem_r;
   logic [DIV_W-1:0] quo_r;
   logic [DIV_W-1:0] dvs_r;
   logic [CNT_W-1:0] cnt_r;
   logic             done_r;
   logic [DIV_W+1:0] shifted_s;
   logic [DIV_W+1:0] trial_s;
   logic             fits_s;

   // Trial subtraction; borrow out of the top bit means the divisor did not fit
   always_comb begin
      shifted_s = {rem_r, quo_r[DIV_W-1]};
      trial_s   = shifted_s - {2'b00, dvs_r};
      fits_s    = ~trial_s[DIV_W+1];
   end

   // Load on start, then shift in one quotient bit per cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_r  <= '0;
         quo_r  <= '0;
         dvs_r  <= '0;
         cnt_r  <= '0;
         done_r <= 1'b0;
      end else if (start) begin
         rem_r  <= '0;
         quo_r  <= dividend;
         dvs_r  <= divisor;
         cnt_r  <= CNT_W'(DIV_W);
         done_r <= 1'b0;
      end else if (cnt_r != '0) begin
         rem_r  <= fits_s ? trial_s[DIV_W:0] : shifted_s[DIV_W:0];
         quo_r  <= {quo_r[DIV_W-2:0], fits_s};
         cnt_r  <= cnt_r - CNT_W'(1);
         done_r <= (cnt_r == CNT_W'(1));
      end else begin
         done_r <= 1'b0;
      end
   end

   assign quotient = quo_r;
   assign done     = done_r;

endmodule

// File: rtl/ecg_interval_calc.sv
// ECG interval calculator: latches fiducials on a start1 rising edge,
// derives PR/QRS/QT/ST/RR and heart rate, strobes feat_valid.
// Optional build macro: ECG_INTERVAL_RR_AVG_EN (4-beat averaged RR).
module ecg_interval_calc
   import ecg_interval_pkg::*;
#(
   parameter int POS_W  = POS_W_DEF,
   parameter int FS     = FS_DEF,
   parameter int DIV_W  = DIV_W_DEF,
   parameter int RR_MIN = RR_MIN_DEF,
   parameter int HR_W   = HR_W_DEF
)(
   input  logic                    clk,
   input  logic                    nReset,
   input  logic                    start1,
   input  logic signed [POS_W-1:0] p_begin,
   input  logic signed [POS_W-1:0] p_end,
   input  logic signed [POS_W-1:0] start_qrs_fin_2,
   input  logic signed [POS_W-1:0] end_qrs_fin_2,
   input  logic signed [POS_W-1:0] t_begin,
   input  logic signed [POS_W-1:0] t_end,
   input  logic signed [POS_W-1:0] r_peak_pos_ref,
   output logic [POS_W-1:0]        pr_int,
   output logic [POS_W-1:0]        qrs_dur,
   output logic [POS_W-1:0]        qt_int,
   output logic [POS_W-1:0]        st_seg,
   output logic [POS_W-1:0]        rr_int,
   output logic [HR_W-1:0]         heart_rate,
   output logic                    feat_valid,
   output logic                    hr_valid,
   output logic                    err_order,
   output logic                    overrun,
   output logic                    busy
);

   localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(hr_dividend(FS));
   localparam logic [POS_W-1:0] RR_MIN_V = POS_W'(RR_MIN);
   localparam logic [HR_W-1:0]  HR_MAX   = {HR_W{1'b1}};

   logic [2:0]              state_r;
   logic [2:0]              state_nxt_s;
   logic                    start1_d_r;
   logic                    rise_s;
   logic signed [POS_W-1:0] pb_r, pe_r, qs_r, qe_r, tb_r, te_r, r_r;
   logic [POS_W-1:0]        r_prev_r;
   logic                    first_beat_r;
   logic [POS_W-1:0]        pr_c_r, qrs_c_r, qt_c_r, st_c_r, rr_c_r;
   logic                    err_c_r;
   logic                    hr_ok_r;
   logic                    order_ok_s;
   logic [POS_W-1:0]        rr_raw_s;
   logic [POS_W-1:0]        rr_rep_s;
   logic                    hr_ok_s;
   logic                    div_start_s;
   logic                    div_done_s;
   logic [DIV_W-1:0]        quotient_s;
   logic [HR_W-1:0]         hr_sat_s;

   assign rise_s      = start1 & ~start1_d_r;
   assign div_start_s = (state_r == ST_CHECK);

   // Fiducial ordering and modular R-R distance from the captured beat
   always_comb begin
      order_ok_s = (pb_r <= pe_r) && (pe_r <= qs_r) && (qs_r <= qe_r) &&
                   (qe_r <= tb_r) && (tb_r <= te_r);
      rr_raw_s   = $unsigned(r_r) - r_prev_r;
   end

`ifdef ECG_INTERVAL_RR_AVG_EN
   logic [POS_W-1:0] hist_r     [4];
   logic [POS_W-1:0] hist_nxt_s [4];
   logic [2:0]       hist_cnt_r;
   logic [2:0]       cnt_nxt_s;
   logic [POS_W+1:0] sum_s;
   logic             accept_s;

   // Shift an acceptable RR into the history and average the four slots
   always_comb begin
      accept_s = ~first_beat_r & (rr_raw_s >= RR_MIN_V);
      if (accept_s) begin
         hist_nxt_s[0] = rr_raw_s;
         hist_nxt_s[1] = hist_r[0];
         hist_nxt_s[2] = hist_r[1];
         hist_nxt_s[3] = hist_r[2];
      end else begin
         hist_nxt_s[0] = hist_r[0];
         hist_nxt_s[1] = hist_r[1];
         hist_nxt_s[2] = hist_r[2];
         hist_nxt_s[3] = hist_r[3];
      end
      if (accept_s && (hist_cnt_r != 3'd4)) begin
         cnt_nxt_s = hist_cnt_r + 3'd1;
      end else begin
         cnt_nxt_s = hist_cnt_r;
      end
      sum_s    = (POS_W+2)'(hist_nxt_s[0]) + (POS_W+2)'(hist_nxt_s[1]) +
                 (POS_W+2)'(hist_nxt_s[2]) + (POS_W+2)'(hist_nxt_s[3]);
      rr_rep_s = sum_s[POS_W+1:2];
      hr_ok_s  = accept_s & (cnt_nxt_s == 3'd4);
   end

   // RR history is committed once per beat in CHECK
   always_ff @(posedge clk) begin
      if (nReset) begin
         for (int i = 0; i < 4; i++) hist_r[i] <= '0;
         hist_cnt_r <= 3'd0;
      end else if (state_r == ST_CHECK) begin
         for (int i = 0; i < 4; i++) hist_r[i] <= hist_nxt_s[i];
         hist_cnt_r <= cnt_nxt_s;
      end else begin
         hist_cnt_r <= hist_cnt_r;
      end
   end
`else
   // Instantaneous RR drives both the report and the divider
   always_comb begin
      rr_rep_s = rr_raw_s;
      hr_ok_s  = ~first_beat_r & (rr_raw_s >= RR_MIN_V);
   end
`endif

   ecg_seq_divider #(
      .DIV_W    (DIV_W)
   ) u_div (
      .clk      (clk),
      .rst      (nReset),
      .start    (div_start_s),
      .dividend (DIVIDEND),
      .divisor  (DIV_W'(rr_rep_s)),
      .quotient (quotient_s),
      .done     (div_done_s)
   );

   // Clamp the quotient to the heart-rate output range
   always_comb begin
      if (quotient_s > DIV_W'(HR_MAX)) begin
         hr_sat_s = HR_MAX;
      end else begin
         hr_sat_s = quotient_s[HR_W-1:0];
      end
   end

   // Next-state logic; a trigger in DONE restarts immediately
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE:    state_nxt_s = rise_s ? ST_CAPTURE : ST_IDLE;
         ST_CAPTURE: state_nxt_s = ST_CHECK;
         ST_CHECK:   state_nxt_s = ST_DIVIDE;
         ST_DIVIDE:  state_nxt_s = div_done_s ? ST_DONE : ST_DIVIDE;
         ST_DONE:    state_nxt_s = rise_s ? ST_CAPTURE : ST_IDLE;
         default:    state_nxt_s = ST_IDLE;
      endcase
   end

   // State register and start1 edge detector
   always_ff @(posedge clk) begin
      if (nReset) begin
         state_r    <= ST_IDLE;
         start1_d_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         start1_d_r <= start1;
      end
   end

   // Capture fiducials, then derive intervals and RR in CHECK
   always_ff @(posedge clk) begin
      if (nReset) begin
         pb_r <= '0; pe_r <= '0; qs_r <= '0; qe_r <= '0;
         tb_r <= '0; te_r <= '0; r_r  <= '0;
         r_prev_r <= '0;
         pr_c_r   <= '0; qrs_c_r <= '0; qt_c_r <= '0; st_c_r <= '0;
         rr_c_r   <= '0;
         err_c_r  <= 1'b0;
         hr_ok_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_CAPTURE: begin
               pb_r <= p_begin;         pe_r <= p_end;
               qs_r <= start_qrs_fin_2; qe_r <= end_qrs_fin_2;
               tb_r <= t_begin;         te_r <= t_end;
               r_r  <= r_peak_pos_ref;
            end
            ST_CHECK: begin
               if (order_ok_s) begin
                  pr_c_r  <= $unsigned(qs_r - pb_r);
                  qrs_c_r <= $unsigned(qe_r - qs_r);
                  qt_c_r  <= $unsigned(te_r - qs_r);
                  st_c_r  <= $unsigned(tb_r - qe_r);
               end else begin
                  pr_c_r  <= '0;
                  qrs_c_r <= '0;
                  qt_c_r  <= '0;
                  st_c_r  <= '0;
               end
               err_c_r  <= ~order_ok_s;
               rr_c_r   <= rr_rep_s;
               hr_ok_r  <= hr_ok_s;
               r_prev_r <= $unsigned(r_r);
            end
            default: begin
               err_c_r <= err_c_r;
            end
         endcase
      end
   end

   // Publish results on divider completion; track busy and overrun
   always_ff @(posedge clk) begin
      if (nReset) begin
         pr_int     <= '0; qrs_dur <= '0; qt_int <= '0; st_seg <= '0;
         rr_int     <= '0;
         heart_rate <= '0;
         feat_valid <= 1'b0;
         hr_valid   <= 1'b0;
         err_order  <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
         first_beat_r <= 1'b1;
      end else begin
         feat_valid <= 1'b0;
         if ((state_r == ST_DIVIDE) && div_done_s) begin
            pr_int       <= pr_c_r;
            qrs_dur      <= qrs_c_r;
            qt_int       <= qt_c_r;
            st_seg       <= st_c_r;
            rr_int       <= rr_c_r;
            err_order    <= err_c_r;
            hr_valid     <= hr_ok_r;
            feat_valid   <= 1'b1;
            busy         <= 1'b0;
            first_beat_r <= 1'b0;
            if (hr_ok_r) begin
               heart_rate <= hr_sat_s;
            end else begin
               heart_rate <= heart_rate;
            end
         end else if (state_r == ST_CAPTURE) begin
            busy <= 1'b1;
         end else begin
            busy <= busy;
         end
         if (rise_s && ((state_r == ST_CAPTURE) || (state_r == ST_CHECK) ||
                        (state_r == ST_DIVIDE))) begin
            overrun <= 1'b1;
         end else begin
            overrun <= overrun;
         end
      end
   end

endmodule
